// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode handshake, flush, forwarding sources and ALU-side outputs.
// master = surrounding pipeline, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            flush;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [2:0]      in_alu_op;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic [RA_W-1:0] in_rd_addr;
    logic            in_reg_write;

    logic            ex_fwd_valid;
    logic [RA_W-1:0] ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            wb_fwd_valid;
    logic [RA_W-1:0] wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_opcode;
    logic [RA_W-1:0] out_rd_addr;
    logic            out_reg_write;

    modport master (
        output flush,
        output in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_alu_op,
        output in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write,
        output ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
        output wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
        output out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_opcode, out_rd_addr, out_reg_write
    );

    modport slave (
        input  flush,
        input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_alu_op,
        input  in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write,
        input  ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
        input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
        input  out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_opcode, out_rd_addr, out_reg_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: one-entry valid/ready stage with flush and operand select.
// Define ID_EX_FORWARD_EN to enable EX/WB operand forwarding and stall-time operand refresh.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [2:0]      alu_op;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic            reg_write;
    } payload_t;

    state_e          state_q, state_d;
    payload_t        pl_q, pl_d, in_pl;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            in_ready, accept;

    assign in_pl = '{
        rs1_data:  bus.in_rs1_data,
        rs2_data:  bus.in_rs2_data,
        imm:       bus.in_imm,
        use_imm:   bus.in_use_imm,
        alu_op:    bus.in_alu_op,
        rs1_addr:  bus.in_rs1_addr,
        rs2_addr:  bus.in_rs2_addr,
        rd_addr:   bus.in_rd_addr,
        reg_write: bus.in_reg_write
    };

    assign in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

`ifdef ID_EX_FORWARD_EN
    // EX beats WB; x0 is hardwired, so a producer "writing" x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] stored,
        input logic            ex_v,
        input logic [RA_W-1:0] ex_rd,
        input logic [XLEN-1:0] ex_d,
        input logic            wb_v,
        input logic [RA_W-1:0] wb_rd,
        input logic [XLEN-1:0] wb_d
    );
        if (addr == '0)                return stored;
        if (ex_v && (ex_rd == addr))   return ex_d;
        if (wb_v && (wb_rd == addr))   return wb_d;
        return stored;
    endfunction

    assign fwd_rs1 = fwd_pick(pl_q.rs1_addr, pl_q.rs1_data,
                              bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign fwd_rs2 = fwd_pick(pl_q.rs2_addr, pl_q.rs2_data,
                              bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
`else
    // Without forwarding, decode interlocks on hazards; forward ports and source indices are sunk.
    assign fwd_rs1 = pl_q.rs1_data;
    assign fwd_rs2 = pl_q.rs2_data;

    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                          bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data,
                          pl_q.rs1_addr, pl_q.rs2_addr};
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            pl_d    = in_pl;
        end else if (state_q == FULL) begin
            if (bus.out_ready) begin
                state_d = EMPTY;
            end else begin
                // Stalled: fold in any producer retiring now so its value survives the stall.
                pl_d.rs1_data = fwd_rs1;
                pl_d.rs2_data = fwd_rs2;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: payload is reset too, because it drives the ALU operands visibly out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = (state_q == FULL);
    assign bus.alu_a         = fwd_rs1;
    assign bus.alu_b         = pl_q.use_imm ? pl_q.imm : fwd_rs2;
    assign bus.alu_opcode    = pl_q.alu_op;
    assign bus.out_rd_addr   = pl_q.rd_addr;
    assign bus.out_reg_write = pl_q.reg_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a one-entry queue model checked every negedge,
// plus directed literal checks. Honours ID_EX_FORWARD_EN the same way as the design.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();
    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most one held instruction, values as the ALU should see them.
    typedef struct {
        logic [31:0] rs1, rs2, imm;
        logic        use_imm;
        logic [2:0]  op;
        logic [4:0]  a1, a2, rd;
        logic        rw;
    } instr_t;

    bit     m_full = 1'b0;
    instr_t m_i;

    function automatic logic [31:0] exp_src(input logic [4:0] a, input logic [31:0] stored);
        logic [31:0] v;
        v = stored;
        if (FWD_EN && a != 5'd0) begin
            if (bus.wb_fwd_valid && bus.wb_fwd_rd == a) v = bus.wb_fwd_data;
            if (bus.ex_fwd_valid && bus.ex_fwd_rd == a) v = bus.ex_fwd_data;
        end
        return v;
    endfunction

    function automatic bit model_accepts();
        return bus.in_valid && (!m_full || bus.out_ready);
    endfunction

    function automatic bit next_full();
        bit stays;
        stays = m_full && !bus.out_ready;
        return !bus.flush && (stays || model_accepts());
    endfunction

    function automatic instr_t next_instr();
        instr_t n;
        n = m_i;
        if (model_accepts()) begin
            n = '{rs1: bus.in_rs1_data, rs2: bus.in_rs2_data, imm: bus.in_imm,
                  use_imm: bus.in_use_imm, op: bus.in_alu_op, a1: bus.in_rs1_addr,
                  a2: bus.in_rs2_addr, rd: bus.in_rd_addr, rw: bus.in_reg_write};
        end else if (m_full && !bus.out_ready) begin
            n.rs1 = exp_src(m_i.a1, m_i.rs1);
            n.rs2 = exp_src(m_i.a2, m_i.rs2);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
        end else begin
            m_full <= next_full();
            m_i    <= next_instr();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_full));
            check("in_ready", 32'(bus.in_ready), 32'(!m_full || bus.out_ready));
            if (m_full) begin
                check("alu_a", bus.alu_a, exp_src(m_i.a1, m_i.rs1));
                check("alu_b", bus.alu_b, m_i.use_imm ? m_i.imm : exp_src(m_i.a2, m_i.rs2));
                check("alu_opcode", 32'(bus.alu_opcode), 32'(m_i.op));
                check("out_rd_addr", 32'(bus.out_rd_addr), 32'(m_i.rd));
                check("out_reg_write", 32'(bus.out_reg_write), 32'(m_i.rw));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_rs1_data  = '0;
        bus.in_rs2_data  = '0;
        bus.in_imm       = '0;
        bus.in_use_imm   = 1'b0;
        bus.in_alu_op    = '0;
        bus.in_rs1_addr  = '0;
        bus.in_rs2_addr  = '0;
        bus.in_rd_addr   = '0;
        bus.in_reg_write = 1'b0;
        bus.ex_fwd_valid = 1'b0;
        bus.ex_fwd_rd    = '0;
        bus.ex_fwd_data  = '0;
        bus.wb_fwd_valid = 1'b0;
        bus.wb_fwd_rd    = '0;
        bus.wb_fwd_data  = '0;
    endtask

    task automatic put(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic use_imm, input logic [2:0] op, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] rd, input logic rw);
        bus.in_valid     = 1'b1;
        bus.in_rs1_data  = rs1;
        bus.in_rs2_data  = rs2;
        bus.in_imm       = imm;
        bus.in_use_imm   = use_imm;
        bus.in_alu_op    = op;
        bus.in_rs1_addr  = a1;
        bus.in_rs2_addr  = a2;
        bus.in_rd_addr   = rd;
        bus.in_reg_write = rw;
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst alu_a", bus.alu_a, 32'd0);
        check("rst alu_b", bus.alu_b, 32'd0);
        check("rst alu_opcode", 32'(bus.alu_opcode), 32'd0);
        check("rst rd", 32'(bus.out_rd_addr), 32'd0);
        check("rst reg_write", 32'(bus.out_reg_write), 32'd0);

        // Passthrough, then an immediate instruction back to back.
        put(32'd5, 32'd3, 32'd0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd4, 1'b1);
        bus.out_ready = 1'b1;
        step();
        check("pass out_valid", 32'(bus.out_valid), 32'd1);
        check("pass alu_a", bus.alu_a, 32'd5);
        check("pass alu_b", bus.alu_b, 32'd3);
        check("pass opcode", 32'(bus.alu_opcode), 32'd1);
        check("pass rd", 32'(bus.out_rd_addr), 32'd4);
        check("pass reg_write", 32'(bus.out_reg_write), 32'd1);

        put(32'h12, 32'h77, 32'hFFFF_FFFC, 1'b1, 3'b011, 5'd1, 5'd2, 5'd6, 1'b0);
        step();
        check("imm alu_b", bus.alu_b, 32'hFFFF_FFFC);
        check("imm alu_a", bus.alu_a, 32'h12);
        check("imm rd", 32'(bus.out_rd_addr), 32'd6);

        // Forward priority while held.
        put(32'h11, 32'h22, 32'd0, 1'b0, 3'b000, 5'd7, 5'd8, 5'd9, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_rd = 5'd7; bus.ex_fwd_data = 32'hAA;
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd7; bus.wb_fwd_data = 32'hBB;
        #1 check("fwd ex over wb", bus.alu_a, FWD_EN ? 32'hAA : 32'h11);
        bus.ex_fwd_valid = 1'b0;
        #1 check("fwd wb only", bus.alu_a, FWD_EN ? 32'hBB : 32'h11);
        bus.wb_fwd_rd = 5'd8; bus.wb_fwd_data = 32'hCC;
        #1 check("fwd wb rs2", bus.alu_b, FWD_EN ? 32'hCC : 32'h22);
        idle();
        bus.out_ready = 1'b1;
        step();

        // x0 is never forwarded.
        put(32'h33, 32'h44, 32'd0, 1'b0, 3'b010, 5'd0, 5'd0, 5'd2, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_rd = 5'd0; bus.ex_fwd_data = 32'hAA;
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd0; bus.wb_fwd_data = 32'hBB;
        #1 check("x0 alu_a", bus.alu_a, 32'h33);
        check("x0 alu_b", bus.alu_b, 32'h44);
        idle();

        // Stall for 3 cycles with a producer retiring only in the first one.
        put(32'h44, 32'h1, 32'd0, 1'b0, 3'b100, 5'd3, 5'd9, 5'd5, 1'b1);
        step();
        bus.out_ready = 1'b0;
        put(32'h99, 32'h98, 32'd0, 1'b0, 3'b101, 5'd10, 5'd11, 5'd10, 1'b1);
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_rd = 5'd9; bus.ex_fwd_data = 32'h10;
        #1 check("stall in_ready c1", 32'(bus.in_ready), 32'd0);
        check("stall alu_b c1", bus.alu_b, FWD_EN ? 32'h10 : 32'h1);
        step();
        bus.ex_fwd_valid = 1'b0;
        #1 check("stall alu_b c2", bus.alu_b, FWD_EN ? 32'h10 : 32'h1);
        check("stall in_ready c2", 32'(bus.in_ready), 32'd0);
        check("stall rd c2", 32'(bus.out_rd_addr), 32'd5);
        step();
        check("stall alu_b c3", bus.alu_b, FWD_EN ? 32'h10 : 32'h1);
        check("stall alu_a c3", bus.alu_a, 32'h44);
        step();
        bus.out_ready = 1'b1;
        #1 check("release in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("next alu_a", bus.alu_a, 32'h99);
        check("next rd", 32'(bus.out_rd_addr), 32'd10);

        // Flush while consuming: the same-cycle rs1=9 instruction is dropped.
        put(32'd9, 32'd8, 32'd0, 1'b0, 3'b110, 5'd12, 5'd13, 5'd14, 1'b1);
        bus.flush = 1'b1;
        step();
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        idle();
        #1 check("flush in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("flush stays empty", 32'(bus.out_valid), 32'd0);

        // Flush while stalled.
        put(32'd7, 32'd6, 32'd0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        put(32'd9, 32'd9, 32'd0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        check("flush held out_valid", 32'(bus.out_valid), 32'd0);
        idle();
        bus.out_ready = 1'b1;
        step();

        // Directed mix of valid/ready/forward patterns, checked by the model.
        for (int i = 0; i < 12; i++) begin
            put(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, i[2], 3'(i), 5'(i % 4),
                5'((i + 1) % 4), 5'(i + 1), i[0]);
            bus.in_valid     = (i % 3 != 2);
            bus.out_ready    = (i % 4 != 1);
            bus.ex_fwd_valid = i[0];
            bus.ex_fwd_rd    = 5'(i % 4);
            bus.ex_fwd_data  = 32'hE000 + i;
            bus.wb_fwd_valid = i[1];
            bus.wb_fwd_rd    = 5'((i + 1) % 4);
            bus.wb_fwd_data  = 32'hB000 + i;
            step();
        end
        idle();
        bus.out_ready = 1'b1;
        step();
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while FULL.
        put(32'd5, 32'd1, 32'd0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        idle();
        bus.out_ready = 1'b0;
        #1 check("pre-reset alu_a", bus.alu_a, 32'd5);
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst alu_a", bus.alu_a, 32'd0);
        check("async rst opcode", 32'(bus.alu_opcode), 32'd0);
        check("async rst in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        check("post-reset out_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
